// File: rtl/reg_writeback_unit.sv
// Write side of the register unit: arbitrates ALU results against buffered load responses
// for the single RF write port and tracks registers with outstanding loads.
module reg_writeback_unit #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [31:0]                   alu_data,
    output logic                          alu_stall,
    input  logic                          ld_issue_valid,
    input  logic [4:0]                    ld_issue_rd,
    input  logic                          ld_resp_valid,
    output logic                          ld_resp_ready,
    input  logic [4:0]                    ld_resp_rd,
    input  logic [31:0]                   ld_resp_data,
    input  logic [2:0]                    ld_resp_funct3,
    input  logic [4:0]                    sb_rs1,
    input  logic [4:0]                    sb_rs2,
    input  logic [4:0]                    sb_rd,
    output logic                          sb_hazard,
    output logic [4:0]                    rd,
    output logic [31:0]                   DataWr,
    output logic                          RUWr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd_mem   [FIFO_DEPTH];
    logic [31:0]   fifo_data_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [SW-1:0] starve_reg;
    logic          busy_reg [32];

    logic          fifo_empty, fifo_full, starved;
    logic          head_win, alu_win, enq, deq;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  format_load = {{24{d[7]}}, d[7:0]};
            3'b001:  format_load = {{16{d[15]}}, d[15:0]};
            3'b100:  format_load = {24'h0, d[7:0]};
            3'b101:  format_load = {16'h0, d[15:0]};
            default: format_load = d;
        endcase
    endfunction

    always_comb begin
        fifo_empty    = (count_reg == '0);
        fifo_full     = (count_reg == CW'(FIFO_DEPTH));
        starved       = (starve_reg == SW'(STARVE_LIMIT));
        head_rd       = fifo_rd_mem[rd_ptr_reg];
        head_data     = fifo_data_mem[rd_ptr_reg];
        head_win      = !fifo_empty && (starved || !alu_valid);
        alu_win       = alu_valid && !head_win;
        alu_stall     = alu_valid && !fifo_empty && starved;
        ld_resp_ready = !fifo_full;
        // x0 responses are handshaken but never occupy a slot
        enq           = ld_resp_valid && !fifo_full && (ld_resp_rd != 5'd0);
        deq           = head_win;
        sb_hazard     = busy_reg[sb_rs1] || busy_reg[sb_rs2] || busy_reg[sb_rd];
        fifo_count    = count_reg;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd_mem[wr_ptr_reg]   <= ld_resp_rd;
            fifo_data_mem[wr_ptr_reg] <= format_load(ld_resp_funct3, ld_resp_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
        end else begin
            if (enq)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (deq)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(enq) - CW'(deq);
            if (deq || fifo_empty)
                starve_reg <= '0;
            else if (alu_win && !starved)
                starve_reg <= starve_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd     <= 5'd0;
            DataWr <= 32'd0;
            RUWr   <= 1'b0;
        end else if (head_win) begin
            rd     <= head_rd;
            DataWr <= head_data;
            RUWr   <= 1'b1;
        end else if (alu_win) begin
            rd     <= alu_rd;
            DataWr <= alu_data;
            RUWr   <= (alu_rd != 5'd0);
        end else begin
            RUWr   <= 1'b0;
        end
    end

    assign busy_reg[0] = 1'b0;

    // An issue to R in the same cycle as R's dequeue keeps R busy
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            always_ff @(posedge clk) begin
                if (rst)
                    busy_reg[gi] <= 1'b0;
                else if (ld_issue_valid && ld_issue_rd == 5'(gi))
                    busy_reg[gi] <= 1'b1;
                else if (deq && head_rd == 5'(gi))
                    busy_reg[gi] <= 1'b0;
            end
        end
    endgenerate
endmodule
